// File: rtl/radix4_ifft_pkg.sv
// radix4_pkg: shared default width, FSM state encoding and bin-slice offsets for radix4_ifft.
package radix4_pkg;
    localparam int W_DEF = 3;
    localparam int N_BINS = 4;
    typedef enum logic [1:0] {IDLE, BFLY1, BFLY2, OUT} state_t;
    function automatic int bin_off(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/radix4_ifft_if.sv
// radix4_ifft_if: frame-in / sample-out stream bundle for radix4_ifft.
interface radix4_ifft_if #(parameter int W = radix4_pkg::W_DEF);
    logic                in_valid;
    logic                in_ready;
    logic [4*W-1:0]      in_real;
    logic [4*W-1:0]      in_imag;
    logic                out_valid;
    logic                out_ready;
    logic signed [W+1:0] out_real;
    logic signed [W+1:0] out_imag;
    logic [1:0]          out_idx;
    logic                out_last;
    modport slave (input in_valid, in_real, in_imag, out_ready,
                   output in_ready, out_valid, out_real, out_imag, out_idx, out_last);
    modport master (output in_valid, in_real, in_imag, out_ready,
                    input in_ready, out_valid, out_real, out_imag, out_idx, out_last);
endinterface

// File: rtl/radix4_ifft_bfly.sv
// radix4_bfly: combinational complex sum/difference pair, one bit of growth.
module radix4_bfly #(parameter int IW = 3) (
    input  logic signed [IW-1:0] ar_i,
    input  logic signed [IW-1:0] ai_i,
    input  logic signed [IW-1:0] br_i,
    input  logic signed [IW-1:0] bi_i,
    output logic signed [IW:0]   sr_o,
    output logic signed [IW:0]   si_o,
    output logic signed [IW:0]   dr_o,
    output logic signed [IW:0]   di_o
);
    assign sr_o = {ar_i[IW-1], ar_i} + {br_i[IW-1], br_i};
    assign si_o = {ai_i[IW-1], ai_i} + {bi_i[IW-1], bi_i};
    assign dr_o = {ar_i[IW-1], ar_i} - {br_i[IW-1], br_i};
    assign di_o = {ai_i[IW-1], ai_i} - {bi_i[IW-1], bi_i};
endmodule

// File: rtl/radix4_ifft.sv
// radix4_ifft: 4-point inverse DFT, two registered butterfly stages then a 4-beat output sequencer.
// Define RADIX4_IFFT_SCALE_EN to apply rounded 1/4 normalisation inside the stage-2 register.
module radix4_ifft
    import radix4_pkg::*;
#(parameter int W = W_DEF) (
    input logic          clk,
    input logic          rst,
    radix4_ifft_if.slave io
);
    localparam int O0 = bin_off(0, W);
    localparam int O1 = bin_off(1, W);
    localparam int O2 = bin_off(2, W);
    localparam int O3 = bin_off(3, W);

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [4*W-1:0]      xr_q, xi_q;
    logic signed [W:0]   a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
    logic signed [W:0]   a_re_q, a_im_q, b_re_q, b_im_q, c_re_q, c_im_q, d_re_q, d_im_q;
    logic signed [W:0]   nd_im;
    logic signed [W+1:0] y_re [N_BINS];
    logic signed [W+1:0] y_im [N_BINS];
    logic [3:0][W+1:0]   yr_q, yi_q;

    function automatic logic signed [W+1:0] scale(input logic signed [W+1:0] v);
`ifdef RADIX4_IFFT_SCALE_EN
        return (v + (W+2)'(2)) >>> 2;
`else
        return v;
`endif
    endfunction

    radix4_bfly #(.IW(W)) u_s1_ac (
        .ar_i(xr_q[O0 +: W]), .ai_i(xi_q[O0 +: W]), .br_i(xr_q[O2 +: W]), .bi_i(xi_q[O2 +: W]),
        .sr_o(a_re), .si_o(a_im), .dr_o(b_re), .di_o(b_im));
    radix4_bfly #(.IW(W)) u_s1_bd (
        .ar_i(xr_q[O1 +: W]), .ai_i(xi_q[O1 +: W]), .br_i(xr_q[O3 +: W]), .bi_i(xi_q[O3 +: W]),
        .sr_o(c_re), .si_o(c_im), .dr_o(d_re), .di_o(d_im));

    // Second operand of the odd pair is d rotated by +j: (-di, dr).
    assign nd_im = -d_im_q;

    radix4_bfly #(.IW(W+1)) u_s2_ac (
        .ar_i(a_re_q), .ai_i(a_im_q), .br_i(c_re_q), .bi_i(c_im_q),
        .sr_o(y_re[0]), .si_o(y_im[0]), .dr_o(y_re[2]), .di_o(y_im[2]));
    radix4_bfly #(.IW(W+1)) u_s2_bd (
        .ar_i(b_re_q), .ai_i(b_im_q), .br_i(nd_im), .bi_i(d_re_q),
        .sr_o(y_re[1]), .si_o(y_im[1]), .dr_o(y_re[3]), .di_o(y_im[3]));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:    state_d = io.in_valid ? BFLY1 : IDLE;
            BFLY1:   state_d = BFLY2;
            BFLY2: begin
                state_d = OUT;
                idx_d   = '0;
            end
            OUT: if (io.out_ready) begin
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd3) ? IDLE : OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            xr_q    <= '0;
            xi_q    <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
            c_re_q  <= '0;
            c_im_q  <= '0;
            d_re_q  <= '0;
            d_im_q  <= '0;
            yr_q    <= '0;
            yi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && io.in_valid) begin
                xr_q <= io.in_real;
                xi_q <= io.in_imag;
            end
            if (state_q == BFLY1) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                b_re_q <= b_re;
                b_im_q <= b_im;
                c_re_q <= c_re;
                c_im_q <= c_im;
                d_re_q <= d_re;
                d_im_q <= d_im;
            end
            if (state_q == BFLY2)
                for (int k = 0; k < N_BINS; k++) begin
                    yr_q[k] <= scale(y_re[k]);
                    yi_q[k] <= scale(y_im[k]);
                end
        end
    end

    // Sample registers are stable through OUT, so the idx mux holds under backpressure.
    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == OUT);
    assign io.out_real  = yr_q[idx_q];
    assign io.out_imag  = yi_q[idx_q];
    assign io.out_idx   = idx_q;
    assign io.out_last  = (idx_q == 2'd3);
endmodule

// File: tb/tb_radix4_ifft.sv
// tb_radix4_ifft: directed frames with a DFT-sum reference model feeding an output scoreboard.
module tb_radix4_ifft;
    localparam int W = 3;

    typedef struct {int re; int im; int idx;} beat_t;

    logic  clk = 1'b0;
    logic  rst;
    int    n_assert = 0;
    int    n_fail = 0;
    beat_t sb[$];

    radix4_ifft_if #(.W(W)) io ();
    radix4_ifft #(.W(W)) dut (.clk(clk), .rst(rst), .io(io.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scl(input int v);
`ifdef RADIX4_IFFT_SCALE_EN
        return (v + 2) >>> 2;
`else
        return v;
`endif
    endfunction

    function automatic void push_expected(input int xr[4], input int xi[4]);
        for (int n = 0; n < 4; n++) begin
            int re = 0;
            int im = 0;
            for (int k = 0; k < 4; k++)
                case ((k * n) % 4)
                    0: begin re += xr[k]; im += xi[k]; end
                    1: begin re -= xi[k]; im += xr[k]; end
                    2: begin re -= xr[k]; im -= xi[k]; end
                    default: begin re += xi[k]; im -= xr[k]; end
                endcase
            sb.push_back('{scl(re), scl(im), n});
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && io.out_valid && io.out_ready) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed idx %0d expected no beat", io.out_idx);
            end
            if (sb.size() > 0) begin
                beat_t e;
                e = sb.pop_front();
                chk("out_real", int'(io.out_real), e.re);
                chk("out_imag", int'(io.out_imag), e.im);
                chk("out_idx", int'(io.out_idx), e.idx);
                chk("out_last", int'(io.out_last), int'(e.idx == 3));
            end
        end
    end

    task automatic send(input int xr[4], input int xi[4]);
        int cyc = 0;
        for (int k = 0; k < 4; k++) begin
            io.in_real[k*W +: W] = xr[k][W-1:0];
            io.in_imag[k*W +: W] = xi[k][W-1:0];
        end
        push_expected(xr, xi);
        io.in_valid = 1'b1;
        while (!io.in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("accept_timeout", int'(cyc < 50), 1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (!(sb.size() == 0 && io.in_ready) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_timeout", int'(cyc < 100), 1);
    endtask

    task automatic wait_beat(input int idx);
        int cyc = 0;
        while (!(io.out_valid && io.out_idx == 2'(idx)) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wait_beat_timeout", int'(cyc < 50), 1);
    endtask

    initial begin
        int rr[4];
        int ri[4];
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.in_real = '0;
        io.in_imag = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", int'(io.in_ready), 1);
        chk("rst_out_valid", int'(io.out_valid), 0);
        chk("rst_out_real", int'(io.out_real), 0);
        chk("rst_out_imag", int'(io.out_imag), 0);
        chk("rst_out_idx", int'(io.out_idx), 0);
        chk("rst_out_last", int'(io.out_last), 0);

        // DC frame with cycle-exact latency and recovery checks
        send('{2, 0, 0, 0}, '{0, 0, 0, 0});
        for (int c = 1; c <= 7; c++) begin
            chk("lat_out_valid", int'(io.out_valid), int'(c >= 3 && c <= 6));
            chk("lat_in_ready", int'(io.in_ready), int'(c == 7));
            if (c < 7) begin
                @(posedge clk); #1;
            end
        end
        chk("dc_sb_empty", sb.size(), 0);

        send('{1, 1, 1, 1}, '{0, 0, 0, 0});
        drain();
        send('{0, 1, 0, 0}, '{0, 0, 0, 0});
        drain();
        send('{-4, -4, -4, -4}, '{-4, -4, -4, -4});
        drain();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                rr[k] = int'($urandom_range(0, 7)) - 4;
                ri[k] = int'($urandom_range(0, 7)) - 4;
            end
            send(rr, ri);
            drain();
        end

        // Backpressure during idx 1 with a competing frame offered
        send('{0, 1, 0, 0}, '{0, 0, 0, 0});
        wait_beat(1);
        io.out_ready = 1'b0;
        io.in_real = {W{1'b1}};
        io.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(io.out_valid), 1);
            chk("bp_out_idx", int'(io.out_idx), 1);
            chk("bp_out_real", int'(io.out_real), scl(0));
            chk("bp_out_imag", int'(io.out_imag), scl(1));
            chk("bp_out_last", int'(io.out_last), 0);
            chk("bp_in_ready", int'(io.in_ready), 0);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_idx2", int'(io.out_idx), 2);
        chk("bp_next_valid2", int'(io.out_valid), 1);
        @(posedge clk); #1;
        chk("bp_next_idx3", int'(io.out_idx), 3);
        chk("bp_next_last3", int'(io.out_last), 1);
        drain();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_no_extra_frame", int'(io.out_valid), 0);
        end

        // Reset while presenting idx 2, then a clean frame
        send('{0, 1, 0, 0}, '{0, 0, 0, 0});
        wait_beat(2);
        io.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(io.out_valid), 0);
        chk("mid_rst_in_ready", int'(io.in_ready), 1);
        chk("mid_rst_out_idx", int'(io.out_idx), 0);
        sb.delete();
        io.out_ready = 1'b1;
        send('{0, 1, 0, 0}, '{0, 0, 0, 0});
        drain();
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/radix4_ifft.md
# radix4_ifft

Four-point radix-4 inverse DFT: the reconstruction side of the 4-point forward transform. Accepts one frame of four complex bins X[0..3] in the same packed layout the forward transform produces and returns the four complex time samples x[0..3] serially, one per beat, over a valid/ready stream. Internally it is a two-stage registered butterfly followed by a 4-beat output sequencer. It sits downstream of the forward transform in the round-trip test path.

## Interface
- W, 3: bin component width; each field is signed two's complement.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  frame offered.
- in_ready  out  1  block can accept a frame.
- in_real  in  4*W  real parts; bin k at [k*W +: W].
- in_imag  in  4*W  imaginary parts; same packing.
- out_valid  out  1  output sample valid.
- out_ready  in  1  sink accepts sample.
- out_real  out  W+2  signed real part of x[out_idx].
- out_imag  out  W+2  signed imaginary part of x[out_idx].
- out_idx  out  2  sample index n.
- out_last  out  1  high with out_idx==3.

## Operation
- Transform: x[n] = sum over k of X[k]·e^{+j2πkn/4}. Unscaled unless the scale option below is compiled in.
- Stage 1 (BFLY1) computes a=X0+X2, b=X0−X2, c=X1+X3, d=X1−X3 at W+1 bits, sign-extended.
- Stage 2 (BFLY2) computes the following at W+2 bits; all values fit, so no overflow is possible:
  - x0 = a+c
  - x2 = a−c
  - x1 = (br−di, bi+dr)
  - x3 = (br+di, bi−dr)
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture inputs and go to BFLY1.
  - BFLY1: always go to BFLY2 after one cycle.
  - BFLY2: results registered; go to OUT with out_idx=0.
  - OUT: out_valid=1. On out_valid&&out_ready: if idx<3, idx+1; if idx==3, go to IDLE.
- in_ready is 0 in every state except IDLE. in_valid is ignored outside IDLE.
- Output hold: out_real, out_imag, out_idx and out_last stay stable while out_valid && !out_ready.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_real=0, out_imag=0, out_idx=0, out_last=0, internal registers 0.
- Reset mid-frame: the frame is discarded with no partial output. out_valid is 0 the cycle after rst.

## Timing
- Acceptance handshake in cycle 0: BFLY1 in cycle 1, BFLY2 in cycle 2, out_valid first high in cycle 3.
- With out_ready held high, beats occupy cycles 3–6 and in_ready returns high in cycle 7.
- Maximum rate is one frame per 7 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- RADIX4_IFFT_SCALE_EN defined: apply the 1/N normalisation. Each output component is (v+2)>>>2 (round half up, arithmetic shift), sign-extended to W+2. Latency is unchanged because the scaling is folded into the BFLY2 register.
- Undefined: raw sums are emitted, equal to 4·x[n].

## Structure
- Package radix4_pkg holds:
  - default W;
  - FSM state enum (IDLE, BFLY1, BFLY2, OUT);
  - bin-slice helper constants for k*W offsets.
- Sub-module radix4_bfly: one complex sum/difference pair, parameterised on input width, purely combinational. Instantiated twice in stage 1 and twice in stage 2; the stage-2 instance for x1/x3 takes the rotated term (−di, dr) as its second operand.

## Test plan
All cases use W=3 and the unscaled build unless stated.
- DC: X0=(2,0), X1..X3=0 → four beats (2,0), idx 0..3, out_last only on idx 3. Scaled build: (1,0) ×4.
- Round trip of forward output for x=4'b0001: X0=(1,0), X1=(1,0), X2=(1,0), X3=(1,0) → (4,0),(0,0),(0,0),(0,0). Scaled build: (1,0),(0,0),(0,0),(0,0).
- Single tone: X1=(1,0), others 0 → (1,0),(0,1),(−1,0),(0,−1).
- Extremes: every bin (−4,−4) → (−16,−16), then (0,0)×3. Scaled build: (−4,−4), then (0,0)×3.
- Backpressure: out_ready low for 5 cycles during idx 1 → outputs and idx held, in_ready=0, a concurrent in_valid is not accepted. After release, idx 2 and idx 3 follow back-to-back.
- Reset in OUT at idx 2 → next cycle out_valid=0, in_ready=1. A fresh single-tone frame then produces correct samples from idx 0.
